// File: rtl/bram_reg_responder_pkg.sv
// Shared definitions for the BRAM-port register responder.
// Holds the register word offsets (byte address bits [11:2]), STATUS
// bit positions, the default sample FIFO depth and a STATUS packer.
package bram_reg_responder_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 8;

    // Word offsets: byte offsets 0x0, 0x4, 0x8, 0xC.
    localparam logic [9:0] WOFF_CONTROL = 10'd0;
    localparam logic [9:0] WOFF_SAMPLE  = 10'd1;
    localparam logic [9:0] WOFF_STATUS  = 10'd2;
    localparam logic [9:0] WOFF_WRCOUNT = 10'd3;

    localparam int STATUS_LEVEL_LSB = 0;
    localparam int STATUS_FULL_BIT  = 8;
    localparam int STATUS_EMPTY_BIT = 9;
    localparam int STATUS_OVF_BIT   = 16;
    localparam int STATUS_DROP_LSB  = 24;

    function automatic logic [31:0] pack_status(
        input logic [7:0] level,
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic [7:0] drop_cnt
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_LEVEL_LSB +: 8] = level;
        s[STATUS_FULL_BIT]       = full;
        s[STATUS_EMPTY_BIT]      = empty;
        s[STATUS_OVF_BIT]        = ovf;
        s[STATUS_DROP_LSB +: 8]  = drop_cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous sample FIFO with valid/ready output side.
// Ports:
//   clk, rstn            clock, async active-low reset
//   wr_en, wr_data       push request and data (dropped if full and no pop)
//   out_valid, out_data  registered head-valid flag and head word (0 when empty)
//   out_ready            consumer accept; pop = out_valid & out_ready
//   level, full, empty   occupancy
module sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic [LW-1:0]    count_next;
    logic             pop;
    logic             push;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign pop   = out_valid & out_ready;
    // When full, a same-edge pop frees the slot the push lands in.
    assign push  = wr_en & (~full | pop);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + LW'(1);
        else if (pop && !push)
            count_next = count - LW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count     <= count_next;
            out_valid <= (count_next != '0);
        end
    end

    // Storage is not reset; the head is masked until valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/bram_reg_responder.sv
// BRAM-port register responder: decodes a simple BRAM-style access port
// into CONTROL / SAMPLE / STATUS / WRCOUNT registers and feeds SAMPLE
// pushes into a sample FIFO drained over a valid/ready interface.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   bram_en, bram_we, bram_addr,    access strobe, byte enables (0 = read),
//   bram_din                        byte address ([11:2] decoded), write data
//   bram_dout                       registered read data
//   ctrl_word                       CONTROL register
//   sample_valid, sample_data,      FIFO head and consumer handshake
//   sample_ready
module bram_reg_responder
    import bram_reg_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bram_en,
    input  logic [3:0]  bram_we,
    input  logic [31:0] bram_addr,
    input  logic [31:0] bram_din,
    output logic [31:0] bram_dout,
    output logic [31:0] ctrl_word,
    output logic        sample_valid,
    output logic [31:0] sample_data,
    input  logic        sample_ready
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [9:0]    word;
    logic          is_wr;
    logic          rd_en;
    logic          ctrl_wr;
    logic          status_wr;
    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [31:0]   ctrl_q;
    logic [31:0]   last_q;
    logic [31:0]   wr_count;
    logic          ovf;
    logic [7:0]    drop_cnt;
    logic [LW-1:0] fifo_level;
    logic [7:0]    level8;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   rd_mux;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{bram_addr[31:12], bram_addr[1:0]};

    assign word      = bram_addr[11:2];
    assign is_wr     = |bram_we;
    assign rd_en     = bram_en & ~is_wr;
    assign ctrl_wr   = bram_en & is_wr & (word == WOFF_CONTROL);
    assign status_wr = bram_en & is_wr & (word == WOFF_STATUS);
    assign push_req  = bram_en & (bram_we == 4'hF) & (word == WOFF_SAMPLE);
    assign pop       = sample_valid & sample_ready;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign drop      = push_req & fifo_full & ~pop;
    assign level8    = {{(8-LW){1'b0}}, fifo_level};
    assign ctrl_word = ctrl_q;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (push_ok),
        .wr_data   (bram_din),
        .out_valid (sample_valid),
        .out_data  (sample_data),
        .out_ready (sample_ready),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pre-edge register values, so a read racing an update sees the old value.
    always_comb begin
        rd_mux = '0;
        case (word)
            WOFF_CONTROL: rd_mux = ctrl_q;
            WOFF_SAMPLE:  rd_mux = last_q;
            WOFF_STATUS:  rd_mux = pack_status(level8, fifo_full, fifo_empty, ovf, drop_cnt);
            WOFF_WRCOUNT: rd_mux = wr_count;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bram_dout <= '0;
            ctrl_q    <= '0;
            last_q    <= '0;
            wr_count  <= '0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (ctrl_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (bram_we[b])
                        ctrl_q[8*b +: 8] <= bram_din[8*b +: 8];
                end
            end
            if (push_ok) begin
                last_q   <= bram_din;
                wr_count <= wr_count + 32'd1;
            end
            // A drop on the same edge as a STATUS clear wins.
            if (drop) begin
                ovf <= 1'b1;
                if (status_wr)
                    drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end else if (status_wr) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end
            if (rd_en)
                bram_dout <= rd_mux;
        end
    end

endmodule

// File: tb/tb_bram_reg_responder.sv
module tb_bram_reg_responder;

    logic        clk;
    logic        rstn;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;
    logic [31:0] ctrl_word;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        sample_ready;

    int n_assert = 0;
    int n_fail   = 0;

    bram_reg_responder #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .bram_dout    (bram_dout),
        .ctrl_word    (ctrl_word),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] din;
        logic        ready;
        logic [31:0] exp_dout;
        logic [31:0] exp_ctrl;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic acc(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din);
        bram_en   = 1'b1;
        bram_we   = we;
        bram_addr = addr;
        bram_din  = din;
        @(negedge clk);
        bram_en = 1'b0;
        bram_we = 4'h0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        acc(4'h0, addr, 32'h0);
        chk(name, bram_dout, exp);
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        bram_en      = 1'b0;
        bram_we      = 4'h0;
        sample_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bram_addr = '0;
        bram_din  = '0;

        //          en    we     addr           din           rdy   dout          ctrl          vld   data
        vecs[0]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,        1'b0, 32'h0000_0200, 32'h0,       1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_000C, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1122_3344, 1'b0, 32'h0,       32'h1122_3344, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 4'h3, 32'h0000_0000, 32'hAABB_CCDD, 1'b0, 32'h0,       32'h1122_CCDD, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,        1'b0, 32'h1122_CCDD, 32'h1122_CCDD, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h1122_CCDD, 32'h1122_CCDD, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        1'b0, 32'h0,        32'h1122_CCDD, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0,       32'h1122_CCDD, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 4'hF, 32'h0000_0004, 32'h5,        1'b0, 32'h0,        32'h1122_CCDD, 1'b1, 32'h5};
        vecs[11] = '{1'b1, 4'hF, 32'h0000_0004, 32'h6,        1'b0, 32'h0,        32'h1122_CCDD, 1'b1, 32'h5};
        vecs[12] = '{1'b1, 4'h7, 32'h0000_0004, 32'h7,        1'b0, 32'h0,        32'h1122_CCDD, 1'b1, 32'h5};
        vecs[13] = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,        1'b0, 32'h0000_0002, 32'h1122_CCDD, 1'b1, 32'h5};
        vecs[14] = '{1'b1, 4'h0, 32'h0000_000C, 32'h0,        1'b0, 32'h2,        32'h1122_CCDD, 1'b1, 32'h5};
        vecs[15] = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,        1'b0, 32'h6,        32'h1122_CCDD, 1'b1, 32'h5};
        vecs[16] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b1, 32'h6,        32'h1122_CCDD, 1'b1, 32'h6};
        vecs[17] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b1, 32'h6,        32'h1122_CCDD, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b1, 32'h6,        32'h1122_CCDD, 1'b0, 32'h0};
        vecs[19] = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,        1'b0, 32'h0000_0200, 32'h1122_CCDD, 1'b0, 32'h0};
        vecs[20] = '{1'b1, 4'h0, 32'hFFFF_F00B, 32'h0,        1'b0, 32'h0000_0200, 32'h1122_CCDD, 1'b0, 32'h0};

        do_reset();
        chk("reset_dout", bram_dout, 32'h0);
        chk("reset_ctrl", ctrl_word, 32'h0);
        chk("reset_valid", {31'h0, sample_valid}, 32'h0);
        chk("reset_data", sample_data, 32'h0);

        for (int i = 0; i < NV; i++) begin
            bram_en      = vecs[i].en;
            bram_we      = vecs[i].we;
            bram_addr    = vecs[i].addr;
            bram_din     = vecs[i].din;
            sample_ready = vecs[i].ready;
            @(negedge clk);
            bram_en = 1'b0;
            bram_we = 4'h0;
            chk($sformatf("vec%0d_dout", i), bram_dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_ctrl", i), ctrl_word, vecs[i].exp_ctrl);
            chk($sformatf("vec%0d_valid", i), {31'h0, sample_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i), sample_data, vecs[i].exp_data);
        end
        sample_ready = 1'b0;

        // Overflow: 10 pushes into a depth-8 FIFO with the consumer stalled.
        do_reset();
        for (int i = 0; i < 10; i++)
            acc(4'hF, 32'h4, 32'h100 + i);
        rd_chk("ovf_status", 32'h8, 32'h0201_0108);
        rd_chk("ovf_wrcount", 32'hC, 32'd8);
        rd_chk("ovf_last", 32'h4, 32'h107);
        chk("ovf_head", sample_data, 32'h100);

        for (int i = 0; i < 260; i++)
            acc(4'hF, 32'h4, 32'hDEAD_0000 + i);
        rd_chk("drop_sat_status", 32'h8, 32'hFF01_0108);
        rd_chk("drop_sat_wrcount", 32'hC, 32'd8);

        acc(4'h4, 32'h8, 32'h0);
        rd_chk("status_clear", 32'h8, 32'h0000_0108);

        // Push and pop on the same edge while full.
        sample_ready = 1'b1;
        acc(4'hF, 32'h4, 32'h200);
        sample_ready = 1'b0;
        chk("pp_head", sample_data, 32'h101);
        rd_chk("pp_status", 32'h8, 32'h0000_0108);
        rd_chk("pp_wrcount", 32'hC, 32'd9);
        rd_chk("pp_last", 32'h4, 32'h200);

        // STATUS read on a popping edge returns the pre-edge level.
        sample_ready = 1'b1;
        rd_chk("pre_edge_status", 32'h8, 32'h0000_0108);
        sample_ready = 1'b0;
        rd_chk("post_pop_status", 32'h8, 32'h0000_0007);

        // WRCOUNT wrap from a preloaded value.
        do_reset();
        force dut.wr_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.wr_count;
        rd_chk("preload_wrcount", 32'hC, 32'hFFFF_FFFF);
        acc(4'hF, 32'h4, 32'h300);
        rd_chk("wrap_wrcount", 32'hC, 32'h0);

        // Asynchronous reset in the middle of a push burst.
        acc(4'hF, 32'h0, 32'hDEAD_BEEF);
        rd_chk("pre_rst_ctrl", 32'h0, 32'hDEAD_BEEF);
        bram_en   = 1'b1;
        bram_we   = 4'hF;
        bram_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            bram_din = 32'h400 + i;
            @(posedge clk);
        end
        #1;
        chk("pre_rst_valid", {31'h0, sample_valid}, 32'h1);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_dout", bram_dout, 32'h0);
        chk("async_ctrl", ctrl_word, 32'h0);
        chk("async_valid", {31'h0, sample_valid}, 32'h0);
        chk("async_data", sample_data, 32'h0);
        bram_en = 1'b0;
        bram_we = 4'h0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rd_chk("post_rst_status", 32'h8, 32'h0000_0200);
        rd_chk("post_rst_wrcount", 32'hC, 32'h0);
        rd_chk("post_rst_last", 32'h4, 32'h0);
        rd_chk("post_rst_ctrl", 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_reg_responder.md
BRAM_REG_RESPONDER -- requirements
Module: bram_reg_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sample FIFO depth in words; SHALL be a power of two, 2..64.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 bram_en  input  1  BRAM port access strobe from initiator.
REQ-005 bram_we  input  4  byte write enables; 0000 = read.
REQ-006 bram_addr  input  32  byte address; bits [11:2] decoded, others ignored.
REQ-007 bram_din  input  32  write data.
REQ-008 bram_dout  output  32  registered read data.
REQ-009 ctrl_word  output  32  current CONTROL register value.
REQ-010 sample_valid  output  1  FIFO head valid.
REQ-011 sample_data  output  32  FIFO head word.
REQ-012 sample_ready  input  1  consumer accepts head when high with sample_valid.

Function
REQ-013 Register map (word offsets): 0x0 CONTROL rw; 0x4 SAMPLE wo-push/read-last; 0x8 STATUS; 0xC WRCOUNT ro; all other offsets read 0, writes ignored.
REQ-014 Access SHALL be sampled on rising clk edge when bram_en=1; bram_en=0 edges SHALL cause no state change.
REQ-015 Read (bram_en=1, bram_we=0000): bram_dout SHALL present the addressed value on the same edge, i.e. valid one cycle after en sampled, and hold until the next read.
REQ-016 Write cycles SHALL leave bram_dout unchanged.
REQ-017 CONTROL write SHALL update only bytes whose bram_we bit is set; ctrl_word = CONTROL, no added latency.
REQ-018 SAMPLE write with bram_we=1111 SHALL push bram_din into FIFO and into LAST register; partial-byte SAMPLE writes SHALL be ignored entirely.
REQ-019 SAMPLE read SHALL return LAST (last accepted push), not FIFO head.
REQ-020 WRCOUNT SHALL increment by 1 per accepted push, wrapping 0xFFFFFFFF -> 0.
REQ-021 STATUS: [7:0] FIFO level, [8] full, [9] empty, [16] overflow sticky, [31:24] drop count saturating at 255, rest 0.
REQ-022 Any write (any we bit) to STATUS SHALL clear overflow and drop count; a drop on the same edge SHALL win (overflow=1, drop count=1).
REQ-023 Push when full without simultaneous pop SHALL be dropped: FIFO, LAST, WRCOUNT unchanged; overflow set; drop count +1.
REQ-024 Push and pop on the same edge when full SHALL both succeed; level unchanged.
REQ-025 Pop occurs on edge with sample_valid=1 and sample_ready=1; sample_ready while empty SHALL be ignored.
REQ-026 sample_valid SHALL be registered, rising the cycle after the first push into an empty FIFO; sample_data stable while valid and not popped.
REQ-027 Read of STATUS/WRCOUNT on an edge that also changes them SHALL return the pre-edge value.

Reset
REQ-028 rstn=0 SHALL asynchronously clear bram_dout, CONTROL, LAST, WRCOUNT, FIFO pointers/level, overflow, drop count; sample_valid=0, sample_data=0.
REQ-029 Reset mid-operation SHALL discard FIFO contents; first access after release SHALL behave as post-reset.

Structure
REQ-030 Shared package SHALL hold register word offsets, STATUS bit positions, and default FIFO_DEPTH.
REQ-031 FIFO SHALL be one sub-module, sync_fifo (valid/ready output, level/full/empty outputs); decode and registers in top.

Verification
REQ-032 Reset, read 0x0,0x4,0x8,0xC -> dout 0,0,0x00000200,0 one cycle after each en.
REQ-033 Write 0x0 we=0011 din=0xAABBCCDD over 0x11223344 -> ctrl_word 0x1122CCDD; read returns same.
REQ-034 Push 0x5,0x6 with sample_ready=0 -> STATUS level 2, WRCOUNT 2, SAMPLE read 0x6; raise ready -> 0x5 then 0x6 popped, valid drops.
REQ-035 Push 10 words, ready=0, depth 8 -> level 8, full, overflow=1, drop=2, WRCOUNT 8; write STATUS -> overflow 0, drop 0.
REQ-036 Full FIFO, push with ready=1 same edge -> level stays 8, no overflow, WRCOUNT +1.
REQ-037 Preload WRCOUNT 0xFFFFFFFF via forced state, one push -> WRCOUNT 0; assert rstn mid-burst -> all outputs 0 asynchronously.
